// File: rtl/ex_stage_md.sv
// Execute stage: operand forwarding, ALU, iterative multiply/divide with HI/LO,
// branch/jump targets and the EX/MEM pipeline register.
module ex_stage_md #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned RAW     = 5,
   parameter int unsigned MUL_LAT = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush_ex,
   input  logic            mem_stall_i,
   input  logic            id_ex_valid,
   input  logic [RAW-1:0]  id_ex_rs,
   input  logic [RAW-1:0]  id_ex_rt,
   input  logic [RAW-1:0]  id_ex_rd,
   input  logic [XLEN-1:0] id_ex_reg_a,
   input  logic [XLEN-1:0] id_ex_reg_b,
   input  logic [XLEN-1:0] id_ex_imm,
   input  logic [XLEN-1:0] id_ex_pc_next,
   input  logic [3:0]      id_ex_alu_op,
   input  logic [2:0]      id_ex_md_op,
   input  logic            id_ex_alu_src,
   input  logic            id_ex_regdst,
   input  logic [5:0]      id_ex_ctrl,
   input  logic [RAW-1:0]  ex_mem_rd_i,
   input  logic            ex_mem_reg_write_i,
   input  logic [XLEN-1:0] ex_mem_fwd_data,
   input  logic [RAW-1:0]  mem_wb_rd,
   input  logic            mem_wb_reg_write,
   input  logic [XLEN-1:0] mem_wb_data,
   output logic            ex_stall_o,
   output logic            md_busy,
   output logic [5:0]      ex_mem_ctrl,
   output logic [XLEN-1:0] ex_mem_alu_out,
   output logic [XLEN-1:0] ex_mem_reg_b,
   output logic [RAW-1:0]  ex_mem_write_reg,
   output logic [RAW-1:0]  ex_mem_rd,
   output logic            ex_mem_zero,
   output logic [XLEN-1:0] ex_mem_pc_branch,
   output logic [XLEN-1:0] ex_mem_pc_jump
);

   localparam int unsigned SHW     = $clog2(XLEN);
   localparam int unsigned CNT_MAX = (MUL_LAT > XLEN) ? MUL_LAT : XLEN;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} md_state_e;

   md_state_e       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d;
   logic [XLEN-1:0] md_a_q, md_b_q, dvs_q;
   logic            sgn_q, qneg_q, rneg_q, dz_q;

   logic [XLEN-1:0] op_a, fwd_b, op_b, alu_res, result;
   logic [SHW-1:0]  shamt;
   logic            md_start, is_mul, md_sgn;
   logic [XLEN-1:0] abs_a, abs_b;
   logic [2*XLEN-1:0] a_ext, b_ext, prod;
   logic [XLEN:0]   div_sh, div_diff;
   logic [XLEN-1:0] rem_n, quo_n;

   // EX/MEM has priority over MEM/WB when both target the same register
   always_comb begin
      op_a = id_ex_reg_a;
      if (ex_mem_reg_write_i && ex_mem_rd_i != '0 && ex_mem_rd_i == id_ex_rs)
         op_a = ex_mem_fwd_data;
      else if (mem_wb_reg_write && mem_wb_rd != '0 && mem_wb_rd == id_ex_rs)
         op_a = mem_wb_data;
      fwd_b = id_ex_reg_b;
      if (ex_mem_reg_write_i && ex_mem_rd_i != '0 && ex_mem_rd_i == id_ex_rt)
         fwd_b = ex_mem_fwd_data;
      else if (mem_wb_reg_write && mem_wb_rd != '0 && mem_wb_rd == id_ex_rt)
         fwd_b = mem_wb_data;
   end

   assign op_b  = id_ex_alu_src ? id_ex_imm : fwd_b;
   assign shamt = op_a[SHW-1:0];

   always_comb begin
      alu_res = op_a + op_b;
      case (id_ex_alu_op)
         4'd1:    alu_res = op_a - op_b;
         4'd2:    alu_res = op_a & op_b;
         4'd3:    alu_res = op_a | op_b;
         4'd4:    alu_res = op_a ^ op_b;
         4'd5:    alu_res = ~(op_a | op_b);
         4'd6:    alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         4'd7:    alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
         4'd8:    alu_res = op_b << shamt;
         4'd9:    alu_res = op_b >> shamt;
         4'd10:   alu_res = $signed(op_b) >>> shamt;
         4'd11:   alu_res = op_b << 16;
         default: alu_res = op_a + op_b;
      endcase
   end

   always_comb begin
      result = alu_res;
      if (id_ex_md_op == 3'd5)      result = hi_q;
      else if (id_ex_md_op == 3'd6) result = lo_q;
   end

   assign is_mul   = (id_ex_md_op == 3'd1) || (id_ex_md_op == 3'd2);
   assign md_sgn   = (id_ex_md_op == 3'd1) || (id_ex_md_op == 3'd3);
   assign md_start = (state_q == S_IDLE) && id_ex_valid && !flush_ex &&
                     (id_ex_md_op >= 3'd1) && (id_ex_md_op <= 3'd4);
   assign abs_a    = (md_sgn && op_a[XLEN-1])  ? -op_a  : op_a;
   assign abs_b    = (md_sgn && fwd_b[XLEN-1]) ? -fwd_b : fwd_b;

   assign ex_stall_o = md_start || (((state_q == S_MUL) || (state_q == S_DIV)) && !flush_ex);
   assign md_busy    = (state_q != S_IDLE);

   // Sign- or zero-extend to 2*XLEN so one truncated multiply serves both forms
   assign a_ext = {{XLEN{sgn_q & md_a_q[XLEN-1]}}, md_a_q};
   assign b_ext = {{XLEN{sgn_q & md_b_q[XLEN-1]}}, md_b_q};
   assign prod  = a_ext * b_ext;

   // Restoring divide on magnitudes; quo_q shifts the dividend out as quotient bits shift in
   assign div_sh   = {rem_q, quo_q[XLEN-1]};
   assign div_diff = div_sh - {1'b0, dvs_q};
   assign rem_n    = div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
   assign quo_n    = {quo_q[XLEN-2:0], ~div_diff[XLEN]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      case (state_q)
         S_IDLE: begin
            if (md_start) begin
               state_d = is_mul ? S_MUL : S_DIV;
               cnt_d   = is_mul ? CW'(MUL_LAT) : CW'(XLEN);
               rem_d   = '0;
               quo_d   = abs_a;
            end
         end
         S_MUL: begin
            if (cnt_q == CW'(1)) begin
               {hi_d, lo_d} = prod;
               state_d      = S_DONE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DIV: begin
            rem_d = rem_n;
            quo_d = quo_n;
            if (cnt_q == CW'(1)) begin
               if (dz_q) begin
                  lo_d = '1;
                  hi_d = md_a_q;
               end else begin
                  lo_d = qneg_q ? -quo_n : quo_n;
                  hi_d = rneg_q ? -rem_n : rem_n;
               end
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DONE: begin
            if (!mem_stall_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (flush_ex) begin
         state_d = S_IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         md_a_q <= '0;
         md_b_q <= '0;
         dvs_q  <= '0;
         sgn_q  <= 1'b0;
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
         dz_q   <= 1'b0;
      end else if (md_start) begin
         md_a_q <= op_a;
         md_b_q <= fwd_b;
         dvs_q  <= abs_b;
         sgn_q  <= md_sgn;
         qneg_q <= md_sgn & (op_a[XLEN-1] ^ fwd_b[XLEN-1]);
         rneg_q <= md_sgn & op_a[XLEN-1];
         dz_q   <= (fwd_b == '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_mem_ctrl      <= '0;
         ex_mem_alu_out   <= '0;
         ex_mem_reg_b     <= '0;
         ex_mem_write_reg <= '0;
         ex_mem_rd        <= '0;
         ex_mem_zero      <= 1'b0;
         ex_mem_pc_branch <= '0;
         ex_mem_pc_jump   <= '0;
      end else if (flush_ex || (!mem_stall_i && (ex_stall_o || !id_ex_valid))) begin
         ex_mem_ctrl      <= '0;
         ex_mem_alu_out   <= '0;
         ex_mem_reg_b     <= '0;
         ex_mem_write_reg <= '0;
         ex_mem_rd        <= '0;
         ex_mem_zero      <= 1'b0;
         ex_mem_pc_branch <= '0;
         ex_mem_pc_jump   <= '0;
      end else if (!mem_stall_i) begin
         ex_mem_ctrl      <= id_ex_ctrl;
         ex_mem_alu_out   <= result;
         ex_mem_reg_b     <= fwd_b;
         ex_mem_write_reg <= id_ex_regdst ? id_ex_rd : id_ex_rt;
         ex_mem_rd        <= id_ex_rd;
         ex_mem_zero      <= (result == '0);
         ex_mem_pc_branch <= id_ex_pc_next + (id_ex_imm << 2);
         ex_mem_pc_jump   <= {id_ex_pc_next[XLEN-1:28], id_ex_imm[25:0], 2'b00};
      end
   end

endmodule

// File: tb/tb_ex_stage_md.sv
// Randomized and directed bench for ex_stage_md against a cycle-level
// behavioural model that computes results with plain integer arithmetic.
module tb_ex_stage_md;
   localparam int unsigned XLEN = 32, RAW = 5, MUL_LAT = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, flush_ex, mem_stall_i, id_ex_valid;
   logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd, ex_mem_rd_i, mem_wb_rd;
   logic [31:0] id_ex_reg_a, id_ex_reg_b, id_ex_imm, id_ex_pc_next;
   logic [31:0] ex_mem_fwd_data, mem_wb_data;
   logic [3:0]  id_ex_alu_op;
   logic [2:0]  id_ex_md_op;
   logic        id_ex_alu_src, id_ex_regdst, ex_mem_reg_write_i, mem_wb_reg_write;
   logic [5:0]  id_ex_ctrl;
   logic        ex_stall_o, md_busy, ex_mem_zero;
   logic [5:0]  ex_mem_ctrl;
   logic [31:0] ex_mem_alu_out, ex_mem_reg_b, ex_mem_pc_branch, ex_mem_pc_jump;
   logic [4:0]  ex_mem_write_reg, ex_mem_rd;

   ex_stage_md #(.XLEN(XLEN), .RAW(RAW), .MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .flush_ex(flush_ex), .mem_stall_i(mem_stall_i),
      .id_ex_valid(id_ex_valid), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
      .id_ex_reg_a(id_ex_reg_a), .id_ex_reg_b(id_ex_reg_b), .id_ex_imm(id_ex_imm),
      .id_ex_pc_next(id_ex_pc_next), .id_ex_alu_op(id_ex_alu_op), .id_ex_md_op(id_ex_md_op),
      .id_ex_alu_src(id_ex_alu_src), .id_ex_regdst(id_ex_regdst), .id_ex_ctrl(id_ex_ctrl),
      .ex_mem_rd_i(ex_mem_rd_i), .ex_mem_reg_write_i(ex_mem_reg_write_i),
      .ex_mem_fwd_data(ex_mem_fwd_data), .mem_wb_rd(mem_wb_rd),
      .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_data(mem_wb_data),
      .ex_stall_o(ex_stall_o), .md_busy(md_busy), .ex_mem_ctrl(ex_mem_ctrl),
      .ex_mem_alu_out(ex_mem_alu_out), .ex_mem_reg_b(ex_mem_reg_b),
      .ex_mem_write_reg(ex_mem_write_reg), .ex_mem_rd(ex_mem_rd), .ex_mem_zero(ex_mem_zero),
      .ex_mem_pc_branch(ex_mem_pc_branch), .ex_mem_pc_jump(ex_mem_pc_jump)
   );

   int tests = 0, fails = 0;

   // model state: phase 0 idle, 1 busy, 2 done
   int          m_phase, m_left;
   logic [31:0] m_hi, m_lo, m_phi, m_plo;
   logic [5:0]  e_ctrl;
   logic [31:0] e_alu, e_regb, e_pcb, e_pcj;
   logic [4:0]  e_wreg, e_rd;
   logic        e_zero;
   logic        s_stall;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic zero_exp();
      e_ctrl = '0; e_alu = '0; e_regb = '0; e_wreg = '0; e_rd = '0;
      e_zero = 1'b0; e_pcb = '0; e_pcj = '0;
   endtask

   task automatic reset_model();
      m_phase = 0; m_left = 0; m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0;
      zero_exp();
   endtask

   function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] rf);
      if (ex_mem_reg_write_i && ex_mem_rd_i != 0 && ex_mem_rd_i == idx) return ex_mem_fwd_data;
      if (mem_wb_reg_write && mem_wb_rd != 0 && mem_wb_rd == idx) return mem_wb_data;
      return rf;
   endfunction

   function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, b);
      int sh;
      sh = int'(a % 32);
      case (op)
         1: return a - b;
         2: return a & b;
         3: return a | b;
         4: return a ^ b;
         5: return ~(a | b);
         6: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         7: return (a < b) ? 32'd1 : 32'd0;
         8: return b << sh;
         9: return b >> sh;
         10: return 32'(int'(b) >>> sh);
         11: return b * 32'h10000;
         default: return a + b;
      endcase
   endfunction

   task automatic md_compute(input logic [2:0] op, input logic [31:0] a, b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'(int'(a));
      sb = longint'(int'(b));
      case (op)
         1: begin p = 64'(sa * sb); m_phi = p[63:32]; m_plo = p[31:0]; end
         2: begin p = {32'd0, a} * {32'd0, b}; m_phi = p[63:32]; m_plo = p[31:0]; end
         3: if (b == 0) begin m_plo = 32'hFFFF_FFFF; m_phi = a; end
            else begin q = sa / sb; r = sa % sb; m_plo = 32'(q); m_phi = 32'(r); end
         default: if (b == 0) begin m_plo = 32'hFFFF_FFFF; m_phi = a; end
            else begin m_plo = a / b; m_phi = a % b; end
      endcase
   endtask

   task automatic check_regs();
      check("ex_mem_ctrl", ex_mem_ctrl, e_ctrl);
      check("ex_mem_alu_out", ex_mem_alu_out, e_alu);
      check("ex_mem_reg_b", ex_mem_reg_b, e_regb);
      check("ex_mem_write_reg", ex_mem_write_reg, e_wreg);
      check("ex_mem_rd", ex_mem_rd, e_rd);
      check("ex_mem_zero", ex_mem_zero, e_zero);
      check("ex_mem_pc_branch", ex_mem_pc_branch, e_pcb);
      check("ex_mem_pc_jump", ex_mem_pc_jump, e_pcj);
   endtask

   // One clock: check combinational outputs, advance model, check registered outputs
   task automatic cycle();
      logic [31:0] a, bf, b, res;
      bit start, stall;
      #1;
      a  = fwd(id_ex_rs, id_ex_reg_a);
      bf = fwd(id_ex_rt, id_ex_reg_b);
      b  = id_ex_alu_src ? id_ex_imm : bf;
      start = (m_phase == 0) && id_ex_valid && !flush_ex && id_ex_md_op >= 1 && id_ex_md_op <= 4;
      stall = start || (m_phase == 1 && !flush_ex);
      check("ex_stall_o", ex_stall_o, stall);
      check("md_busy", md_busy, m_phase != 0);
      s_stall = ex_stall_o;
      res = (id_ex_md_op == 5) ? m_hi : (id_ex_md_op == 6) ? m_lo : alu_model(id_ex_alu_op, a, b);
      if (flush_ex) zero_exp();
      else if (!mem_stall_i) begin
         if (stall || !id_ex_valid) zero_exp();
         else begin
            e_ctrl = id_ex_ctrl; e_alu = res; e_regb = bf;
            e_wreg = id_ex_regdst ? id_ex_rd : id_ex_rt; e_rd = id_ex_rd;
            e_zero = (res == 0);
            e_pcb = id_ex_pc_next + id_ex_imm * 4;
            e_pcj = (id_ex_pc_next & 32'hF000_0000) | ((id_ex_imm & 32'h03FF_FFFF) * 4);
         end
      end
      if (flush_ex) m_phase = 0;
      else if (m_phase == 0) begin
         if (start) begin
            md_compute(id_ex_md_op, a, bf);
            m_left  = (id_ex_md_op <= 2) ? MUL_LAT : XLEN;
            m_phase = 1;
         end
      end else if (m_phase == 1) begin
         m_left--;
         if (m_left == 0) begin m_hi = m_phi; m_lo = m_plo; m_phase = 2; end
      end else if (!mem_stall_i) m_phase = 0;
      @(posedge clk);
      @(negedge clk);
      check_regs();
   endtask

   task automatic instr(input logic [3:0] aop, input logic [2:0] mop,
                        input logic [31:0] ra, rb, im, input logic src);
      id_ex_valid = 1; id_ex_alu_op = aop; id_ex_md_op = mop;
      id_ex_reg_a = ra; id_ex_reg_b = rb; id_ex_imm = im; id_ex_alu_src = src;
      id_ex_rs = 5'd1; id_ex_rt = 5'd2; id_ex_rd = 5'd3; id_ex_regdst = 1;
      id_ex_ctrl = 6'b100000; id_ex_pc_next = 32'h0040_0004;
      ex_mem_reg_write_i = 0; ex_mem_rd_i = 0; ex_mem_fwd_data = 0;
      mem_wb_reg_write = 0; mem_wb_rd = 0; mem_wb_data = 0;
      flush_ex = 0; mem_stall_i = 0;
   endtask

   task automatic run_md(output int cnt);
      cnt = 0;
      for (int i = 0; i < 200; i++) begin
         cycle();
         if (s_stall) cnt++;
         else break;
      end
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom % 8)
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom % 16);
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt;
      instr(0, 0, 0, 0, 0, 0);
      id_ex_valid = 0;
      rst_n = 0;
      reset_model();
      @(negedge clk);
      check_regs();
      check("reset_stall", ex_stall_o, 0);
      check("reset_busy", md_busy, 0);
      rst_n = 1;

      // forwarding
      instr(0, 0, 32'h5, 32'h6, 32'h1, 1);
      id_ex_rs = 3; ex_mem_reg_write_i = 1; ex_mem_rd_i = 3; ex_mem_fwd_data = 32'h11;
      mem_wb_reg_write = 1; mem_wb_rd = 3; mem_wb_data = 32'h22;
      cycle(); check("fwd_exmem_wins", ex_mem_alu_out, 32'h12);
      ex_mem_rd_i = 4;
      cycle(); check("fwd_memwb", ex_mem_alu_out, 32'h23);
      ex_mem_rd_i = 0; mem_wb_rd = 0; id_ex_rs = 0;
      cycle(); check("fwd_rd0_regfile", ex_mem_alu_out, 32'h6);

      // targets
      instr(0, 0, 1, 2, 32'hFFFF_FFFC, 0);
      id_ex_pc_next = 32'h0040_0010;
      cycle();
      check("pc_branch", ex_mem_pc_branch, 32'h0040_0000);
      check("pc_jump", ex_mem_pc_jump, 32'h0FFF_FFF0);

      // MULT -3 * 7
      instr(0, 1, 32'hFFFF_FFFD, 32'd7, 0, 0);
      run_md(cnt);
      check("mult_stall_cycles", cnt, MUL_LAT + 1);
      check("model_mult_lo", m_lo, 32'hFFFF_FFEB);
      instr(0, 6, 0, 0, 0, 0); cycle(); check("mflo_after_mult", ex_mem_alu_out, 32'hFFFF_FFEB);
      instr(0, 5, 0, 0, 0, 0); cycle(); check("mfhi_after_mult", ex_mem_alu_out, 32'hFFFF_FFFF);

      // DIV -7 / 2
      instr(0, 3, 32'hFFFF_FFF9, 32'd2, 0, 0);
      run_md(cnt);
      check("div_stall_cycles", cnt, XLEN + 1);
      instr(0, 6, 0, 0, 0, 0); cycle(); check("mflo_after_div", ex_mem_alu_out, 32'hFFFF_FFFD);
      instr(0, 5, 0, 0, 0, 0); cycle(); check("mfhi_after_div", ex_mem_alu_out, 32'hFFFF_FFFF);

      // DIVU 5 / 0
      instr(0, 4, 32'd5, 32'd0, 0, 0);
      run_md(cnt);
      instr(0, 6, 0, 0, 0, 0); cycle(); check("mflo_div0", ex_mem_alu_out, 32'hFFFF_FFFF);
      instr(0, 5, 0, 0, 0, 0); cycle(); check("mfhi_div0", ex_mem_alu_out, 32'd5);

      // DIV most-negative / -1
      instr(0, 3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      run_md(cnt);
      instr(0, 6, 0, 0, 0, 0); cycle(); check("mflo_ovf", ex_mem_alu_out, 32'h8000_0000);
      instr(0, 5, 0, 0, 0, 0); cycle(); check("mfhi_ovf", ex_mem_alu_out, 32'd0);

      // flush on the 10th cycle of a DIV
      instr(0, 3, 32'd100, 32'd7, 0, 0);
      repeat (9) cycle();
      flush_ex = 1;
      cycle();
      check("flush_stall_drop", s_stall, 0);
      check("flush_busy_drop", md_busy, 0);
      check("flush_bubble", ex_mem_ctrl, 0);
      instr(0, 6, 0, 0, 0, 0); cycle(); check("lo_kept_after_flush", ex_mem_alu_out, 32'h8000_0000);
      instr(0, 5, 0, 0, 0, 0); cycle(); check("hi_kept_after_flush", ex_mem_alu_out, 32'd0);

      // downstream hold
      instr(0, 0, 32'hABCC, 0, 32'd1, 1);
      cycle(); check("hold_load", ex_mem_alu_out, 32'hABCD);
      instr(3, 0, 32'hF0, 0, 32'h0F, 1);
      mem_stall_i = 1;
      repeat (3) begin
         cycle();
         check("hold_alu", ex_mem_alu_out, 32'hABCD);
         check("hold_ctrl", ex_mem_ctrl, 6'b100000);
      end
      mem_stall_i = 0;
      cycle(); check("hold_release", ex_mem_alu_out, 32'hFF);

      // randomized traffic; the front end holds its instruction while stalled
      s_stall = 0;
      for (int i = 0; i < 700; i++) begin
         if (!s_stall) begin
            id_ex_valid   = ($urandom % 8) != 0;
            id_ex_alu_op  = 4'($urandom);
            case ($urandom % 16)
               0, 1:    id_ex_md_op = 3'(1 + $urandom % 4);
               2:       id_ex_md_op = 3'd5;
               3:       id_ex_md_op = 3'd6;
               4:       id_ex_md_op = 3'd7;
               default: id_ex_md_op = 3'd0;
            endcase
            id_ex_rs = 5'($urandom % 4); id_ex_rt = 5'($urandom % 4); id_ex_rd = 5'($urandom);
            id_ex_reg_a = rnd_val(); id_ex_reg_b = rnd_val(); id_ex_imm = rnd_val();
            id_ex_pc_next = 32'($urandom);
            id_ex_alu_src = (id_ex_md_op >= 1 && id_ex_md_op <= 4) ? 1'b0 : 1'($urandom);
            id_ex_regdst = 1'($urandom); id_ex_ctrl = 6'($urandom);
         end
         ex_mem_reg_write_i = 1'($urandom); ex_mem_rd_i = 5'($urandom % 4); ex_mem_fwd_data = rnd_val();
         mem_wb_reg_write = 1'($urandom); mem_wb_rd = 5'($urandom % 4); mem_wb_data = rnd_val();
         flush_ex    = ($urandom % 40) == 0;
         mem_stall_i = ($urandom % 6) == 0;
         cycle();
      end

      // asynchronous reset while a MULT is in flight and EX/MEM holds data
      instr(0, 0, 32'h1234, 0, 32'h1, 1);
      cycle();
      instr(0, 1, 32'd9, 32'd9, 0, 0);
      mem_stall_i = 1;
      cycle();
      cycle();
      check("pre_reset_busy", md_busy, 1);
      id_ex_valid = 0; id_ex_md_op = 0; mem_stall_i = 0;
      #2 rst_n = 0;
      #1;
      reset_model();
      check_regs();
      check("async_reset_busy", md_busy, 0);
      check("async_reset_stall", ex_stall_o, 0);
      @(negedge clk);
      rst_n = 1;
      instr(0, 5, 0, 0, 0, 0); cycle(); check("hi_zero_after_reset", ex_mem_alu_out, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
